// File: rtl/mux_select_arbiter.sv
// Round-robin owner of the downstream 2:1 mux select line.
// Locks the grant to one source for a packet (or a capped burst) and steers sel to it.
module mux_select_arbiter #(
   parameter int unsigned MAX_BURST = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_0,
   input  logic                               req_1,
   input  logic                               last_0,
   input  logic                               last_1,
   input  logic                               ready,
   output logic                               sel,
   output logic                               grant_0,
   output logic                               grant_1,
   output logic                               busy,
   output logic                               xfer,
   output logic [$clog2(MAX_BURST + 1)-1:0]   beat_cnt
);

   localparam int unsigned      CNT_W    = $clog2(MAX_BURST + 1);
   // Count value of the final beat a grant may carry before forced release.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic             sel_q, sel_d;
   logic             grant_0_q, grant_0_d;
   logic             grant_1_q, grant_1_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             xfer_c;
   logic             cap_hit_c;
   logic             release_c;

   // Beat moves when the owning source presents data and the consumer takes it.
   assign xfer_c    = ((grant_0_q & req_0) | (grant_1_q & req_1)) & ready;
   assign cap_hit_c = (beat_cnt_q == CNT_LAST);

   // Grant ends on an accepted beat that closes the packet or fills the burst.
   always_comb begin
      release_c = 1'b0;
      if (xfer_c) begin
         if (cap_hit_c) begin
            release_c = 1'b1;
         end else if (state_q == LOCK0) begin
            release_c = last_0;
         end else if (state_q == LOCK1) begin
            release_c = last_1;
         end
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         sel_q      <= 1'b0;
         grant_0_q  <= 1'b0;
         grant_1_q  <= 1'b0;
         busy_q     <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         sel_q      <= sel_d;
         grant_0_q  <= grant_0_d;
         grant_1_q  <= grant_1_d;
         busy_q     <= busy_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Next-state: arbitrate only from IDLE, leave a lock only on release.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_0 && req_1) begin
               state_d = prio_q ? LOCK1 : LOCK0;
            end else if (req_0) begin
               state_d = LOCK0;
            end else if (req_1) begin
               state_d = LOCK1;
            end
         end
         LOCK0, LOCK1: begin
            if (release_c) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values: grants follow the next state, sel only moves on lock entry.
   always_comb begin
      prio_d     = prio_q;
      sel_d      = sel_q;
      beat_cnt_d = beat_cnt_q;
      grant_0_d  = (state_d == LOCK0);
      grant_1_d  = (state_d == LOCK1);
      busy_d     = grant_0_d | grant_1_d;

      if (state_q == IDLE) begin
         if (state_d == LOCK0) begin
            sel_d = 1'b0;
         end else if (state_d == LOCK1) begin
            sel_d = 1'b1;
         end
      end

      if (release_c) begin
         beat_cnt_d = '0;
         prio_d     = (state_q == LOCK0);
      end else if (xfer_c) begin
         beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
   end

   assign sel      = sel_q;
   assign grant_0  = grant_0_q;
   assign grant_1  = grant_1_q;
   assign busy     = busy_q;
   assign xfer     = xfer_c;
   assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Self-checking bench for mux_select_arbiter, built with MAX_BURST=4.
// Each row drives {req_0,req_1,last_0,last_1,ready} and expects
// {grant_0,grant_1,sel,busy,xfer,beat_cnt[2:0]} during that same cycle.
module tb_mux_select_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req_0, req_1, last_0, last_1, ready;
   logic       sel, grant_0, grant_1, busy, xfer;
   logic [2:0] beat_cnt;
   logic [7:0] obs;
   logic [7:0] want;
   logic [7:0] exp_q [$];
   int         checks;
   int         passed;

   mux_select_arbiter #(.MAX_BURST(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_0    (req_0),
      .req_1    (req_1),
      .last_0   (last_0),
      .last_1   (last_1),
      .ready    (ready),
      .sel      (sel),
      .grant_0  (grant_0),
      .grant_1  (grant_1),
      .busy     (busy),
      .xfer     (xfer),
      .beat_cnt (beat_cnt)
   );

   assign obs = {grant_0, grant_1, sel, busy, xfer, beat_cnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset with inputs quiet; returns at posedge+1 in IDLE.
   task automatic apply_reset();
      {req_0, req_1, last_0, last_1, ready} = 5'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] stim [$];
      logic [7:0] tab [$];
      // Values while reset is held from time zero.
      exp_q.push_back(8'b0);
      #2;
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) $display("FAIL reset_initial: got %b want %b", obs, want);
      else passed++;
      apply_reset();
      // Bring source 1 into LOCK1 with three accepted beats.
      stim = '{5'b01000, 5'b01001, 5'b01001, 5'b01001, 5'b01000};
      tab  = '{8'b0_0_0_0_0_000, 8'b0_1_1_1_1_000, 8'b0_1_1_1_1_001,
               8'b0_1_1_1_1_010, 8'b0_1_1_1_0_011};
      for (int i = 0; i < int'(stim.size()); i++) begin
         {req_0, req_1, last_0, last_1, ready} = stim[i];
         exp_q.push_back(tab[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL reset_setup row %0d: got %b want %b", i, obs, want);
         else passed++;
         @(posedge clk);
         #1;
      end
      // Mid-packet reset must clear outputs without a clock edge.
      {req_0, req_1, last_0, last_1, ready} = 5'b01001;
      rst_n = 1'b0;
      exp_q.push_back(8'b0);
      #1;
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) $display("FAIL reset_async: got %b want %b", obs, want);
      else passed++;
      // After release, both requesting: source 0 is granted first.
      {req_0, req_1, last_0, last_1, ready} = 5'b11000;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(8'b1_0_0_1_0_000);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) $display("FAIL reset_first_grant: got %b want %b", obs, want);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_source();
      logic [4:0] stim [$];
      logic [7:0] tab [$];
      apply_reset();
      stim = '{5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b00000, 5'b00000};
      tab  = '{8'b0_0_0_0_0_000, 8'b1_0_0_1_1_000, 8'b1_0_0_1_1_001,
               8'b1_0_0_1_1_010, 8'b0_0_0_0_0_000, 8'b0_0_0_0_0_000};
      for (int i = 0; i < int'(stim.size()); i++) begin
         {req_0, req_1, last_0, last_1, ready} = stim[i];
         exp_q.push_back(tab[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL single_source row %0d: got %b want %b", i, obs, want);
         else passed++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_round_robin();
      logic [4:0] stim [$];
      logic [7:0] tab [$];
      apply_reset();
      // Requests stay high through each release cycle; arbitration waits for IDLE.
      stim = '{5'b11001, 5'b11001, 5'b11111, 5'b11001, 5'b11001, 5'b11111,
               5'b11001, 5'b11001, 5'b11111, 5'b11001, 5'b11001, 5'b11111,
               5'b00000};
      tab  = '{8'b0_0_0_0_0_000, 8'b1_0_0_1_1_000, 8'b1_0_0_1_1_001,
               8'b0_0_0_0_0_000, 8'b0_1_1_1_1_000, 8'b0_1_1_1_1_001,
               8'b0_0_1_0_0_000, 8'b1_0_0_1_1_000, 8'b1_0_0_1_1_001,
               8'b0_0_0_0_0_000, 8'b0_1_1_1_1_000, 8'b0_1_1_1_1_001,
               8'b0_0_1_0_0_000};
      for (int i = 0; i < int'(stim.size()); i++) begin
         {req_0, req_1, last_0, last_1, ready} = stim[i];
         exp_q.push_back(tab[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL round_robin row %0d: got %b want %b", i, obs, want);
         else passed++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] stim [$];
      logic [7:0] tab [$];
      apply_reset();
      // last_0 during a ready=0 cycle must be ignored.
      stim = '{5'b10000, 5'b10001, 5'b10000, 5'b10001, 5'b10100, 5'b10101,
               5'b00000};
      tab  = '{8'b0_0_0_0_0_000, 8'b1_0_0_1_1_000, 8'b1_0_0_1_0_001,
               8'b1_0_0_1_1_001, 8'b1_0_0_1_0_010, 8'b1_0_0_1_1_010,
               8'b0_0_0_0_0_000};
      for (int i = 0; i < int'(stim.size()); i++) begin
         {req_0, req_1, last_0, last_1, ready} = stim[i];
         exp_q.push_back(tab[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL backpressure row %0d: got %b want %b", i, obs, want);
         else passed++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_burst_cap();
      logic [4:0] stim [$];
      logic [7:0] tab [$];
      apply_reset();
      stim = '{5'b11001, 5'b11001, 5'b11001, 5'b11001, 5'b11001, 5'b11001,
               5'b11001, 5'b00000};
      tab  = '{8'b0_0_0_0_0_000, 8'b1_0_0_1_1_000, 8'b1_0_0_1_1_001,
               8'b1_0_0_1_1_010, 8'b1_0_0_1_1_011, 8'b0_0_0_0_0_000,
               8'b0_1_1_1_1_000, 8'b0_1_1_1_0_001};
      for (int i = 0; i < int'(stim.size()); i++) begin
         {req_0, req_1, last_0, last_1, ready} = stim[i];
         exp_q.push_back(tab[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL burst_cap row %0d: got %b want %b", i, obs, want);
         else passed++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_request_drop();
      logic [4:0] stim [$];
      logic [7:0] tab [$];
      apply_reset();
      stim = '{5'b11001, 5'b11001, 5'b01001, 5'b01001, 5'b01001, 5'b01001,
               5'b01001, 5'b11101, 5'b11001, 5'b01000};
      tab  = '{8'b0_0_0_0_0_000, 8'b1_0_0_1_1_000, 8'b1_0_0_1_0_001,
               8'b1_0_0_1_0_001, 8'b1_0_0_1_0_001, 8'b1_0_0_1_0_001,
               8'b1_0_0_1_0_001, 8'b1_0_0_1_1_001, 8'b0_0_0_0_0_000,
               8'b0_1_1_1_0_000};
      for (int i = 0; i < int'(stim.size()); i++) begin
         {req_0, req_1, last_0, last_1, ready} = stim[i];
         exp_q.push_back(tab[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         checks++;
         if (obs !== want) $display("FAIL request_drop row %0d: got %b want %b", i, obs, want);
         else passed++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      {req_0, req_1, last_0, last_1, ready} = 5'b0;
      test_reset();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_burst_cap();
      test_request_drop();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
